// File: rtl/fixed_power.sv
// -----------------------------------------------------------------------------
// fixed_power
// Iterative fixed-point exponentiator. Raises an unsigned Q10.10 base to a
// 3-bit integer power and performs one 20x20 multiply per clock.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   in_valid     in   1   request strobe, sampled only while idle
//   in_data_1    in  20   base x, unsigned Q10.10
//   in_data_2    in   3   exponent n, 0..7
//   busy         out  1   high from capture until the return to idle
//   out_valid    out  1   one-cycle result strobe
//   out_data     out 20   x^n, Q10.10 (held until the next result)
//   out_overflow out  1   result exceeded the Q10.10 range (sticky per op)
//
// Configuration macro
//   FIXED_POWER_SATURATE_EN : when defined, the accumulator clamps to 20'hFFFFF
//                             on the first overflowing step and stays there.
//                             When undefined, the accumulator wraps.
// -----------------------------------------------------------------------------
module fixed_power #(
   parameter int FRAC = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [19:0] in_data_1,
   input  logic [2:0]  in_data_2,
   output logic        busy,
   output logic        out_valid,
   output logic [19:0] out_data,
   output logic        out_overflow
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [19:0] ONE_Q   = 20'h00400;
   localparam logic [19:0] SAT_MAX = 20'hFFFFF;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [19:0] r_x;
   logic [19:0] r_acc;
   logic [2:0]  r_cnt;
   logic        r_ovf;
   logic        r_busy;
   logic        r_out_valid;
   logic [19:0] r_out_data;
   logic        r_out_ovf;

   logic [19:0] w_x_nxt;
   logic [19:0] w_acc_nxt;
   logic [2:0]  w_cnt_nxt;
   logic        w_ovf_nxt;
   logic        w_busy_nxt;
   logic        w_out_valid_nxt;
   logic [19:0] w_out_data_nxt;
   logic        w_out_ovf_nxt;

   logic [39:0] w_prod;
   logic [29:0] w_q;
   logic        w_step_ovf;
   logic [19:0] w_step_acc;
   logic        w_unused_lsb;

   // Full 40-bit product, then drop FRAC fraction bits (floor, no rounding).
   assign w_prod       = {20'd0, r_acc} * {20'd0, r_x};
   assign w_q          = w_prod[FRAC +: 30];
   assign w_unused_lsb = ^w_prod[FRAC-1:0];
   assign w_step_ovf   = |w_q[29:20];

`ifdef FIXED_POWER_SATURATE_EN
   // Once any step has overflowed the accumulator is pinned at the maximum,
   // even if later multiplies by x<1.0 would bring it back into range.
   assign w_step_acc = (r_ovf || w_step_ovf) ? SAT_MAX : w_q[19:0];
`else
   assign w_step_acc = w_q[19:0];
`endif

   // Next-state and next-register values for the control FSM and datapath.
   always_comb begin
      w_state_nxt     = r_state;
      w_x_nxt         = r_x;
      w_acc_nxt       = r_acc;
      w_cnt_nxt       = r_cnt;
      w_ovf_nxt       = r_ovf;
      w_busy_nxt      = r_busy;
      w_out_valid_nxt = 1'b0;
      w_out_data_nxt  = r_out_data;
      w_out_ovf_nxt   = r_out_ovf;
      case (r_state)
         ST_IDLE: begin
            if (in_valid) begin
               w_state_nxt = ST_MULT;
               w_x_nxt     = in_data_1;
               w_cnt_nxt   = in_data_2;
               w_acc_nxt   = ONE_Q;
               w_ovf_nxt   = 1'b0;
               w_busy_nxt  = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_MULT: begin
            if (r_cnt != 3'd0) begin
               w_acc_nxt = w_step_acc;
               w_cnt_nxt = r_cnt - 3'd1;
               w_ovf_nxt = r_ovf | w_step_ovf;
            end else begin
               w_state_nxt     = ST_DONE;
               w_out_valid_nxt = 1'b1;
               w_out_data_nxt  = r_acc;
               w_out_ovf_nxt   = r_ovf;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath and registered output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x         <= 20'd0;
         r_acc       <= 20'd0;
         r_cnt       <= 3'd0;
         r_ovf       <= 1'b0;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= 20'd0;
         r_out_ovf   <= 1'b0;
      end else begin
         r_x         <= w_x_nxt;
         r_acc       <= w_acc_nxt;
         r_cnt       <= w_cnt_nxt;
         r_ovf       <= w_ovf_nxt;
         r_busy      <= w_busy_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_ovf   <= w_out_ovf_nxt;
      end
   end

   assign busy         = r_busy;
   assign out_valid    = r_out_valid;
   assign out_data     = r_out_data;
   assign out_overflow = r_out_ovf;

endmodule

// File: doc/fixed_power.md
# fixed_power

Iterative fixed-point exponentiator: raises an unsigned Q10.10 value to a 3-bit integer power, one multiply per clock. It is the inverse of the team's n-th-root block. It feeds that block's 20-bit root output back to reconstruct the original operand, and it serves as a stand-alone power unit behind the same `in_valid`/`out_valid` handshake.

## Interface
- `FRAC`, 10: fractional bits of operand and result (Q10.10).
- `clk`  in  1: sole clock; all state updates on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: single-cycle request strobe; sampled only in IDLE.
- `in_data_1`  in  20: base x, unsigned Q10.10.
- `in_data_2`  in  3: exponent n, 0..7.
- `busy`  out  1: high from capture edge until the return to IDLE.
- `out_valid`  out  1: one-cycle result strobe.
- `out_data`  out  20: x^n, Q10.10.
- `out_overflow`  out  1: result exceeded Q10.10 range; valid with `out_valid`.

## Operation
- States:
  - IDLE: `in_valid`=1 → MULT. Capture x, cnt=n, acc=20'h00400 (1.0), ovf=0.
  - MULT: cnt≠0 → acc=step(acc), cnt−1. cnt==0 → DONE, out_data=acc, out_overflow=ovf, out_valid=1.
  - DONE: unconditional → IDLE, out_valid=0.
- step: p = acc × x (40-bit full product); q = p >> FRAC (floor, truncation only, no rounding).
  - q[29:20]≠0 sets sticky ovf.
  - Non-overflow: acc = q[19:0].
- `in_valid` in MULT/DONE is ignored; the request is dropped, not queued.
- `out_data`/`out_overflow` hold until the next result; only reset clears them.
- n=0: result 1.0 for any x, including x=0.
- x=0, n≥1: result 0, no overflow.
- Reset values: `busy`=0, `out_valid`=0, `out_data`=0, `out_overflow`=0, state IDLE, acc=0, cnt=0.
- Reset asserted mid-operation aborts immediately; no result is produced.

## Timing
- Capture at edge E0 (IDLE, `in_valid`=1); `busy` high after E0.
- Multiplies occur at edges E0+1 .. E0+n.
- `out_valid`=1 and `out_data` valid after edge E0+n+1.
- `out_valid`=0 and `busy`=0 after E0+n+2.
- Earliest next capture is edge E0+n+3.
- Latency n+1 cycles from capture to strobe; throughput one op per n+3 cycles.
- The multiplier is combinational within one cycle (20×20); no pipelining.

## Configuration
- `FIXED_POWER_SATURATE_EN` defined:
  - On the first overflowing step, acc = 20'hFFFFF.
  - acc stays at 20'hFFFFF for the remaining steps, even if x<1.0.
  - Result is 20'hFFFFF with `out_overflow`=1.
- Undefined: acc = q[19:0] (wrap) on every step; `out_overflow` still reports sticky ovf.

## Test plan
- x=20'h00800 (2.0), n=3 → `out_data`=20'h02000 (8.0), `out_overflow`=0, `out_valid` one cycle after E0+4.
- x=20'h00600 (1.5), n=2 → 20'h00900 (2.25); x=20'h00001, n=2 → 20'h00000 (truncation), no overflow.
- x=20'hFFC00 (1023.0), n=2 → `out_overflow`=1; `out_data`=20'hFFFFF with `FIXED_POWER_SATURATE_EN`, 20'h00400 without.
- n=0, x=20'h00000 → 20'h00400, strobe after E0+1; second `in_valid` pulsed at E0+1 is dropped, only one `out_valid` pulse.
- Round trip: root block output for in_data_1=10'd27, in_data_2=3 fed here with n=3 → integer part `out_data[19:10]`=26 or 27 (floor truncation both directions).
- `rst_n` low at E0+2 of an n=7 op → `busy`/`out_valid`/`out_data` 0 immediately; after release, new request x=20'h00400, n=5 → 20'h00400.
